alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Output buffering stage that sits directly downstream of the ALU function units (OR, AND, ADD, etc.). Each cycle it can capture one unit result tagged with its opcode and carry, and compute the Zero/Negative/Carry/Parity flags at capture time. It stores up to DEPTH entries in a first-word-fall-through FIFO and presents them to the consumer over a valid/ready handshake. It also keeps a wrapping count of delivered results for debug and bench checking.

## Interface
- WIDTH, 8, data width of opA/opB/result
- DEPTH, 4, FIFO entries; power of two, at least 2
- OPW, 4, opcode tag width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of FIFO contents
- in_valid  input  1  upstream result valid
- in_ready  output  1  space available; equals (count != DEPTH)
- in_result  input  WIDTH  result from ALU function unit
- in_opcode  input  OPW  opcode that produced in_result
- in_carry  input  1  carry/borrow out from unit (0 for logic ops)
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  consumer accepts head entry
- out_result  output  WIDTH  head entry result
- out_opcode  output  OPW  head entry opcode
- out_flags  output  4  head flags: [0]=Z, [1]=N, [2]=C, [3]=P
- count  output  clog2(DEPTH)+1  current occupancy
- delivered  output  16  number of completed pops, wraps at 16'hFFFF to 0

## Operation
- Push: in_valid && in_ready at a rising edge. The entry {in_result, in_opcode, flags} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Flags computed from the inputs at push time:
  - Z = (in_result == 0)
  - N = in_result[WIDTH-1]
  - C = in_carry
  - P = XOR-reduce of in_result
- Pop: out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH and delivered increments.
- Output data is always driven from the entry at rd_ptr (first-word fall-through). When out_valid=0, the out_result/out_opcode/out_flags values are don't-care.
- Simultaneous push and pop when 0 < count < DEPTH: both take effect and count is unchanged.
- When full (count == DEPTH), in_ready=0 and no push occurs even if a pop happens in the same cycle. There is no pass-through when full.
- When empty, out_valid=0 and no pop occurs. A push in that cycle is accepted.
- flush=1: rd_ptr, wr_ptr and count are cleared to 0; delivered is unchanged. flush overrides any push or pop in the same cycle, and neither is counted.
- in_ready and out_valid depend only on registered count. There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Pointer wrap is purely modulo DEPTH. count uses one extra bit so that full and empty are distinct.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - count=0 and both pointers 0
  - delivered=0
  - out_valid=0, in_ready=1
- Storage contents are not reset.
- Latency: an entry pushed at edge N appears on out_* with out_valid=1 from edge N onward, i.e. it is visible in cycle N+1.
- Back-to-back sustained throughput is one entry per cycle with both sides ready.
- Deassertion of rst_n mid-transfer: the first push can be accepted at the first rising edge at which rst_n is high.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Test plan
- Reset, then a single push of in_result=8'h0F, opcode=4'h1, carry=0, followed by a pop. Required: out_result=8'h0F, out_flags=4'b0000, and delivered 0 -> 1.
- Push 8'h00, then 8'h80 with carry=1, then pop both. Required flags, in order: first 4'b0001, then 4'b1110.
- Push 4 entries with out_ready=0. Required: count=4 and in_ready=0. A 5th push is ignored, and the 4 pops return the data in push order.
- Fill to 3 entries, then hold in_valid=1 and out_ready=1 for 10 cycles. Required: count stays 3, the data order is preserved across the pointer wrap, and delivered=10.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle. Required: the pop occurs, the push is rejected, count=3, and in_ready=1 the next cycle.
- Apply flush with push and pop both active, then apply rst_n=0 mid-stream. Required:
  - after flush: count=0, out_valid=0, delivered unchanged
  - after reset: delivered=0 asynchronously

Source files
------------

// File: rtl/alu_result_fifo.sv
// First-word-fall-through result buffer placed after the ALU function units.
// Captures result/opcode with Z/N/C/P flags and delivers them over valid/ready.
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OPW   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [OPW-1:0]           in_opcode,
    input  logic                     in_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [OPW-1:0]           out_opcode,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              delivered
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OPW-1:0]   opcode;
        logic [3:0]       flags;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] wr_ptr_next, rd_ptr_next;
    logic [CW-1:0] count_next;
    logic [15:0]   delivered_next;
    logic          push, pop;

    // Handshake status comes only from registered occupancy.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Flags are frozen at capture time: {P, C, N, Z}.
    assign wr_entry.result = in_result;
    assign wr_entry.opcode = in_opcode;
    assign wr_entry.flags  = {^in_result, in_carry, in_result[WIDTH-1], (in_result == '0)};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        count_next     = count;
        delivered_next = delivered;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr_next    = rd_ptr + AW'(1);
                delivered_next = delivered + 16'd1;
            end
            unique case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            delivered <= '0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            delivered <= delivered_next;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign out_result = mem[rd_ptr].result;
    assign out_opcode = mem[rd_ptr].opcode;
    assign out_flags  = mem[rd_ptr].flags;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: flags, FWFT order, full/empty edges,
// sustained throughput across pointer wrap, flush and asynchronous reset.
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_result;
    logic [3:0]  in_opcode;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic [3:0]  out_opcode;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic [15:0] delivered;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_delivered = 16'd0;

    alu_result_fifo #(.WIDTH(8), .DEPTH(4), .OPW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_opcode  (in_opcode),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags),
        .count      (count),
        .delivered  (delivered)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d, input logic [3:0] op, input logic c);
        in_valid  = 1'b1;
        in_result = d;
        in_opcode = op;
        in_carry  = c;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_opcode = '0; in_carry = 1'b0;
        step(); step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (delivered !== 16'd0) begin errors++; $display("FAIL reset_delivered got=%0d want=0", delivered); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        push_one(8'h0F, 4'h1, 1'b0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d want=1", count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
        checks++; if (out_result !== 8'h0F) begin errors++; $display("FAIL single_result got=%h want=0f", out_result); end
        checks++; if (out_opcode !== 4'h1) begin errors++; $display("FAIL single_opcode got=%h want=1", out_opcode); end
        checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL single_flags got=%b want=0000", out_flags); end
        checks++; if (delivered !== 16'd0) begin errors++; $display("FAIL single_delivered_pre got=%0d want=0", delivered); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_delivered = 16'd1;
        checks++; if (delivered !== exp_delivered) begin errors++; $display("FAIL single_delivered got=%0d want=%0d", delivered, exp_delivered); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_flags();
        push_one(8'h00, 4'h2, 1'b0);
        push_one(8'h80, 4'h3, 1'b1);
        checks++; if (out_flags !== 4'b0001) begin errors++; $display("FAIL flags_zero got=%b want=0001", out_flags); end
        out_ready = 1'b1;
        step();
        checks++; if (out_flags !== 4'b1110) begin errors++; $display("FAIL flags_neg got=%b want=1110", out_flags); end
        checks++; if (out_result !== 8'h80) begin errors++; $display("FAIL flags_result got=%h want=80", out_result); end
        step();
        out_ready = 1'b0;
        exp_delivered += 16'd2;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flags_count got=%0d want=0", count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push_one(8'h10 + 8'(i), 4'(i), 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d want=4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        push_one(8'hEE, 4'hE, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignored got=%0d want=4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_result !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_order[%0d] got=%h want=%h", i, out_result, 8'h10 + 8'(i)); end
            step();
        end
        out_ready = 1'b0;
        exp_delivered += 16'd4;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) push_one(8'hA0 + 8'(i), 4'h5, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = 8'hA3 + 8'(i);
            checks++;
            if (out_result !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, out_result, 8'hA0 + 8'(i)); end
            step();
        end
        in_valid = 1'b0;
        exp_delivered += 16'd10;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_count got=%0d want=3", count); end
        checks++; if (delivered !== exp_delivered) begin errors++; $display("FAIL b2b_delivered got=%0d want=%0d", delivered, exp_delivered); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_result !== 8'hAA + 8'(i)) begin errors++; $display("FAIL b2b_tail[%0d] got=%h want=%h", i, out_result, 8'hAA + 8'(i)); end
            step();
        end
        out_ready = 1'b0;
        exp_delivered += 16'd3;
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 4; i++) push_one(8'hB0 + 8'(i), 4'h7, 1'b0);
        in_valid  = 1'b1;
        in_result = 8'hFF;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fpp_count got=%0d want=3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fpp_in_ready got=%b want=1", in_ready); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_result !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL fpp_order[%0d] got=%h want=%h", i, out_result, 8'hB0 + 8'(i)); end
            step();
        end
        out_ready = 1'b0;
        exp_delivered += 16'd4;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_no_ff got=%b want=0", out_valid); end
    endtask

    task automatic test_flush_reset();
        push_one(8'hC0, 4'h1, 1'b0);
        push_one(8'hC1, 4'h1, 1'b0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=1'b0", out_valid); end
        checks++; if (delivered !== exp_delivered) begin errors++; $display("FAIL flush_delivered got=%0d want=%0d", delivered, exp_delivered); end
        push_one(8'hD0, 4'h2, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_delivered += 16'd1;
        push_one(8'hD1, 4'h2, 1'b0);
        push_one(8'hD2, 4'h2, 1'b0);
        checks++; if (delivered !== exp_delivered) begin errors++; $display("FAIL prereset_delivered got=%0d want=%0d", delivered, exp_delivered); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (delivered !== 16'd0) begin errors++; $display("FAIL async_delivered got=%0d want=0", delivered); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_count got=%0d want=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got=%b want=0", out_valid); end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_result = 8'h5A;
        in_opcode = 4'h9;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL post_reset_count got=%0d want=1", count); end
        checks++; if (out_result !== 8'h5A) begin errors++; $display("FAIL post_reset_result got=%h want=5a", out_result); end
        checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL post_reset_flags got=%b want=0000", out_flags); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_full();
        test_back_to_back();
        test_full_pop_push();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
